// File: rtl/fir_capture_sequencer_if.sv
// Signal bundle between fir_capture_sequencer (slave) and the surrounding
// buttons / UART / coefficient / FIR / FIFO blocks (master).
interface fir_capture_sequencer_if #(
  parameter int N_COEF = 16
);
  localparam int AW = $clog2(N_COEF);

  // Handshake semantics: coef_valid_i and sample_valid_i are one-cycle strobes,
  // each high cycle is one transfer with no back-pressure. tx_ready_i is a level
  // (UART idle). rd_o and tx_start_o are one-cycle pulses. wr_o is qualified by
  // full_fifo_i in the same cycle, so a write never lands on a full FIFO.
  logic          pulsador_carga_coef_i;
  logic          send_i;
  logic          coef_valid_i;
  logic          full_fir_reg_i;
  logic          sample_valid_i;
  logic          full_fifo_i;
  logic          empty_i;
  logic          tx_ready_i;
  logic          en_recepcion_o;
  logic [AW-1:0] coef_addr_o;
  logic          en_fir_o;
  logic          wr_o;
  logic          rd_o;
  logic          tx_start_o;
  logic          led_full_o;
  logic [2:0]    state_o;

  modport slave (
    input  pulsador_carga_coef_i, send_i, coef_valid_i, full_fir_reg_i,
           sample_valid_i, full_fifo_i, empty_i, tx_ready_i,
    output en_recepcion_o, coef_addr_o, en_fir_o, wr_o, rd_o, tx_start_o,
           led_full_o, state_o
  );

  modport master (
    output pulsador_carga_coef_i, send_i, coef_valid_i, full_fir_reg_i,
           sample_valid_i, full_fifo_i, empty_i, tx_ready_i,
    input  en_recepcion_o, coef_addr_o, en_fir_o, wr_o, rd_o, tx_start_o,
           led_full_o, state_o
  );
endinterface

// File: rtl/fir_capture_sequencer.sv
// Sequencer for coefficient load -> FIR priming -> FIFO capture -> UART dump.
// Optional macro AUTO_SEND_EN: FULL proceeds to SEND after one cycle without a press.
module fir_capture_sequencer #(
  parameter int N_COEF = 16,
  parameter int GUARD  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fir_capture_sequencer_if.slave  bus
);

  localparam int AW = $clog2(N_COEF);
  localparam int GW = $clog2(GUARD + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PRIME     = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_FULL      = 3'd4,
    ST_SEND      = 3'd5,
    ST_SEND_WAIT = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_load_d;
  logic          r_send_d;
  logic          r_load_evt;
  logic          r_send_evt;
  logic [AW-1:0] r_coef_addr;
  logic [AW-1:0] w_coef_addr_nxt;
  logic [GW-1:0] r_guard;
  logic [GW-1:0] w_guard_nxt;
  logic          r_en_rec;
  logic          r_en_fir;
  logic          r_rd;
  logic          r_tx_start;
  logic          r_led_full;
  logic          w_rd_nxt;
  logic          w_tx_start_nxt;
  logic          w_guard_done;

  // Press events are registered so the FSM reacts one cycle after detection.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_load_d   <= 1'b0;
      r_send_d   <= 1'b0;
      r_load_evt <= 1'b0;
      r_send_evt <= 1'b0;
    end else begin
      r_load_d   <= bus.pulsador_carga_coef_i;
      r_send_d   <= bus.send_i;
      r_load_evt <= bus.pulsador_carga_coef_i & ~r_load_d;
      r_send_evt <= bus.send_i & ~r_send_d;
    end
  end

  // r_guard holds the number of completed cycles since the rd_o edge.
  assign w_guard_done = (r_guard >= GW'(GUARD));

  always_comb begin
    w_state_nxt     = r_state;
    w_coef_addr_nxt = r_coef_addr;
    w_guard_nxt     = r_guard;
    w_rd_nxt        = 1'b0;
    w_tx_start_nxt  = 1'b0;
    if (r_load_evt) begin
      w_state_nxt     = ST_LOAD;
      w_coef_addr_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_LOAD: begin
          if (bus.coef_valid_i) begin
            if (r_coef_addr == AW'(N_COEF - 1)) begin
              w_coef_addr_nxt = '0;
              w_state_nxt     = ST_PRIME;
            end else begin
              w_coef_addr_nxt = r_coef_addr + 1'b1;
            end
          end
        end
        ST_PRIME: begin
          if (bus.full_fir_reg_i) w_state_nxt = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (bus.full_fifo_i) w_state_nxt = ST_FULL;
        end
        ST_FULL: begin
`ifdef AUTO_SEND_EN
          w_state_nxt = ST_SEND;
`else
          if (r_send_evt) w_state_nxt = ST_SEND;
`endif
        end
        ST_SEND: begin
          // An empty FIFO ends the dump; coefficients stay loaded for the next capture.
          if (bus.empty_i) begin
            w_state_nxt = ST_PRIME;
          end else if (bus.tx_ready_i) begin
            w_rd_nxt    = 1'b1;
            w_guard_nxt = GW'(1);
            w_state_nxt = ST_SEND_WAIT;
          end
        end
        ST_SEND_WAIT: begin
          w_tx_start_nxt = r_rd;
          if (!w_guard_done) w_guard_nxt = r_guard + 1'b1;
          if (w_guard_done && bus.tx_ready_i) w_state_nxt = ST_SEND;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they align with state_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_coef_addr <= '0;
      r_guard     <= '0;
      r_en_rec    <= 1'b0;
      r_en_fir    <= 1'b0;
      r_led_full  <= 1'b0;
      r_rd        <= 1'b0;
      r_tx_start  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_coef_addr <= w_coef_addr_nxt;
      r_guard     <= w_guard_nxt;
      r_en_rec    <= (w_state_nxt == ST_LOAD);
      r_en_fir    <= (w_state_nxt == ST_PRIME) || (w_state_nxt == ST_CAPTURE);
      r_led_full  <= (w_state_nxt == ST_FULL);
      r_rd        <= w_rd_nxt;
      r_tx_start  <= w_tx_start_nxt;
    end
  end

  assign bus.wr_o           = (r_state == ST_CAPTURE) & bus.sample_valid_i
                            & ~bus.full_fifo_i & ~r_load_evt;
  assign bus.en_recepcion_o = r_en_rec;
  assign bus.coef_addr_o    = r_coef_addr;
  assign bus.en_fir_o       = r_en_fir;
  assign bus.rd_o           = r_rd;
  assign bus.tx_start_o     = r_tx_start;
  assign bus.led_full_o     = r_led_full;
  assign bus.state_o        = r_state;

endmodule

// File: doc/fir_capture_sequencer.md
# fir_capture_sequencer

FSM controller that sequences the coefficient-load → FIR → FIFO capture → UART dump flow. It sits between the pushbuttons, the UART receive/transmit blocks, the coefficient block, the FIR filter and the sample FIFO. It drives their enables and handshakes so that no FIFO write occurs while a dump is in progress and no read occurs while capturing. Coefficients are counted internally, so the load phase ends without an external "done" strobe.

## Interface
Parameters:
- N_COEF, 16, number of coefficients per load; coef_addr_o width is $clog2(N_COEF).
- GUARD, 2, minimum cycles after rd_o before tx_ready_i is sampled again; legal values are 2 or more.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset; asynchronous assert, active-low (0 = reset).
- pulsador_carga_coef_i  in  1  coefficient-load button, already synchronized and debounced; the block edge-detects it.
- send_i  in  1  dump button, already synchronized and debounced; the block edge-detects it.
- coef_valid_i  in  1  one-cycle strobe from UART RX, one per received coefficient.
- full_fir_reg_i  in  1  FIR delay line is filled.
- sample_valid_i  in  1  one-cycle strobe, FIR output sample valid.
- full_fifo_i  in  1  FIFO full.
- empty_i  in  1  FIFO empty.
- tx_ready_i  in  1  UART TX idle and able to accept a byte.
- en_recepcion_o  out  1  coefficient storage enable.
- coef_addr_o  out  $clog2(N_COEF)  coefficient write index.
- en_fir_o  out  1  FIR enable.
- wr_o  out  1  FIFO write.
- rd_o  out  1  FIFO read, one-cycle pulse.
- tx_start_o  out  1  UART TX start, one-cycle pulse.
- led_full_o  out  1  FIFO-full indicator.
- state_o  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, LOAD=1, PRIME=2, CAPTURE=3, FULL=4, SEND=5, SEND_WAIT=6.
- Edge detect: a press is the cycle where the input is 1 and its registered copy is 0. Held buttons generate exactly one event.
- Global priority: a load press in any state moves the FSM to LOAD, clears coef_addr_o and drops wr_o, rd_o and tx_start_o. This includes a load press during LOAD, which restarts the count.
- IDLE: all outputs are 0. A load press moves to LOAD.
- LOAD:
  - en_recepcion_o=1.
  - Each coef_valid_i increments coef_addr_o.
  - coef_valid_i while coef_addr_o==N_COEF-1 moves to PRIME. coef_addr_o wraps to 0.
- PRIME: en_fir_o=1. Move to CAPTURE when full_fir_reg_i=1.
- CAPTURE:
  - en_fir_o=1.
  - wr_o = sample_valid_i & ~full_fifo_i. This is combinational from the registered state, so a write is never issued while the FIFO is full.
  - full_fifo_i=1 moves to FULL.
- FULL:
  - en_fir_o=0 and led_full_o=1.
  - A send press moves to SEND.
  - A send press in any other state is ignored.
- SEND:
  - If empty_i=1, move to PRIME. Coefficients are retained, and the FIR is re-enabled for a new capture.
  - Otherwise, if tx_ready_i=1, pulse rd_o and move to SEND_WAIT.
- SEND_WAIT:
  - tx_start_o pulses exactly 1 cycle after rd_o, when FIFO data is valid.
  - A guard counter runs from rd_o. The FSM returns to SEND on the first cycle where tx_ready_i=1 and at least GUARD cycles have elapsed since rd_o.
- Simultaneous events: when full_fifo_i and sample_valid_i are both high in CAPTURE, no write occurs and the FSM moves to FULL.

## Timing
- All outputs are registered except wr_o.
- Reset values: state IDLE, coef_addr_o=0, and every output 0.
- Reset applied mid-dump aborts the dump immediately. The FIFO contents are not flushed by this block.
- Latency from a press to the state change is 1 cycle after the edge-detect register. The first output change therefore appears 2 cycles after the input rises.
- rd_o goes high in the cycle after SEND samples tx_ready_i=1.
- Minimum dump period is GUARD+1 cycles per word.

## Configuration
- AUTO_SEND_EN defined: FULL moves to SEND after exactly 1 cycle with no press; led_full_o pulses for that 1 cycle.
- AUTO_SEND_EN undefined: FULL holds until a send press.

## Test plan
- Reset with rst_i=0 mid-CAPTURE, then release → state_o=0, all outputs 0, coef_addr_o=0.
- Load press, then 16 coef_valid_i strobes spaced 5 cycles → en_recepcion_o high throughout, coef_addr_o counts 0..15, state_o=2 after strobe 16, en_fir_o=1.
- Load press after 7 strobes → coef_addr_o=0, state stays LOAD, and 16 further strobes are needed to reach PRIME.
- full_fir_reg_i=1, 8 sample_valid_i strobes with full_fifo_i asserted after the 8th → exactly 8 wr_o pulses, then state_o=4, led_full_o=1, en_fir_o=0. A strobe arriving together with full_fifo_i produces no wr_o.
- Send press in FULL with 3 words, tx_ready_i falling 1 cycle after tx_start_o and rising 10 cycles later → 3 rd_o pulses, each followed 1 cycle later by tx_start_o. After empty_i the FSM returns to PRIME, then CAPTURE.
- With AUTO_SEND_EN, fill the FIFO → SEND is entered 1 cycle after FULL with no press. A send press in CAPTURE is ignored.
